wb_stage_regfile: RTL and testbench

//   Write-back end of the MEM/WB pipeline boundary: consumes the registered MEM/WB

---
 rtl/mips_pkg.sv | 24 ++
 rtl/regfile_2r1w.sv | 42 ++++
 rtl/wb_stage_regfile.sv | 81 ++++++++
 tb/tb_wb_stage_regfile.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MEM/WB boundary, the write-back stage,
// and the EX forwarding unit.
//   DATA_W / ADDR_W   : default datapath and register-index widths
//   WB_REGWRITE_BIT   : bit of the 2-bit MEM/WB control word that enables the write
//   WB_MEMTOREG_BIT   : bit that selects load data over the ALU result
//   REG_ZERO          : index of the hardwired-zero register
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // Write-back data select: load data when MemtoReg is set, otherwise ALU result.
  function automatic logic [DATA_W-1:0] wb_select(input logic            mem_to_reg,
                                                  input logic [DATA_W-1:0] load_data,
                                                  input logic [DATA_W-1:0] alu_data);
    return mem_to_reg ? load_data : alu_data;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read / 1-write register file with hardwired-zero entry 0.
//   clk, reset         : rising-edge clock, asynchronous active-high clear
//   we, waddr, wdata   : synchronous write port (writes to index 0 are dropped)
//   raddr_a, raddr_b   : combinational read indices
//   rdata_a, rdata_b   : array contents (no bypass); index 0 always reads 0
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, but mask it anyway so $zero reads 0 by construction.
  always_comb begin
    rdata_a = (raddr_a == REG_ZERO) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == REG_ZERO) ? '0 : regs[raddr_b];
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile: write-back stage of the MEM/WB boundary plus register file.
//   clk, reset                  : rising-edge clock, asynchronous active-high reset
//   wb_ctrl                     : [1]=RegWrite, [0]=MemtoReg
//   read_data, alu_result       : MEM/WB load data and ALU result
//   wb_dest                     : MEM/WB destination register index
//   rs_addr, rt_addr            : ID-stage read indices
//   rs_data, rt_data            : read data with same-cycle write bypass
//   fwd_valid/fwd_dest/fwd_data : WB forwarding tap for the EX forwarding unit
//   commit_count                : number of committed register writes (wraps)
module wb_stage_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_ctrl,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  commit_count
);

  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] raw_a;
  logic [DATA_W-1:0] raw_b;

  assign wr_data = wb_select(wb_ctrl[WB_MEMTOREG_BIT], read_data, alu_result);

  // Reset gates the write so neither the bypass nor the forwarding tap can
  // leak a value while the file is being cleared.
  assign wr_en = !reset && wb_ctrl[WB_REGWRITE_BIT] && (wb_dest != REG_ZERO);

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .waddr   (wb_dest),
    .wdata   (wr_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  // Bypass: the write landing at this edge is already visible on the read
  // ports. wr_en excludes $zero, so index 0 falls through to the masked read.
  always_comb begin
    rs_data = (wr_en && (rs_addr == wb_dest)) ? wr_data : raw_a;
    rt_data = (wr_en && (rt_addr == wb_dest)) ? wr_data : raw_b;
  end

  assign fwd_valid = wr_en;
  assign fwd_dest  = wb_dest;
  assign fwd_data  = reset ? '0 : wr_data;

  // Wraps silently at 2**CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_count <= '0;
    end else if (wr_en) begin
      commit_count <= commit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage_regfile.sv
module tb_wb_stage_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic [1:0]    wb_ctrl;
  logic [DW-1:0] read_data;
  logic [DW-1:0] alu_result;
  logic [AW-1:0] wb_dest;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;

  logic [DW-1:0] rs_data,  rt_data,  fwd_data;
  logic          fwd_valid;
  logic [AW-1:0] fwd_dest;
  logic [31:0]   commit_count;

  logic [DW-1:0] rs_data4, rt_data4, fwd_data4;
  logic          fwd_valid4;
  logic [AW-1:0] fwd_dest4;
  logic [3:0]    commit_count4;

  wb_stage_regfile u_dut (
    .clk          (clk),
    .reset        (reset),
    .wb_ctrl      (wb_ctrl),
    .read_data    (read_data),
    .alu_result   (alu_result),
    .wb_dest      (wb_dest),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .fwd_valid    (fwd_valid),
    .fwd_dest     (fwd_dest),
    .fwd_data     (fwd_data),
    .commit_count (commit_count)
  );

  wb_stage_regfile #(.CNT_W(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .wb_ctrl      (wb_ctrl),
    .read_data    (read_data),
    .alu_result   (alu_result),
    .wb_dest      (wb_dest),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data4),
    .rt_data      (rt_data4),
    .fwd_valid    (fwd_valid4),
    .fwd_dest     (fwd_dest4),
    .fwd_data     (fwd_data4),
    .commit_count (commit_count4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] model_regs [32];
  logic [31:0]   model_cnt;

  int n_vec;
  int n_err;
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] model_wr_data();
    return wb_ctrl[0] ? read_data : alu_result;
  endfunction

  function automatic logic model_wr_en();
    return !reset && wb_ctrl[1] && (wb_dest != 5'd0);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (reset || a == 5'd0) return '0;
    if (model_wr_en() && a == wb_dest) return model_wr_data();
    return model_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_cnt = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_wb(input logic [1:0] ctrl, input logic [DW-1:0] rd,
                          input logic [DW-1:0] alu, input logic [AW-1:0] dest);
    wb_ctrl    = ctrl;
    read_data  = rd;
    alu_result = alu;
    wb_dest    = dest;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rs_addr = a;
    rt_addr = b;
  endtask

  // Cross one rising edge, updating the model from the values held across it,
  // and return at the following falling edge.
  task automatic tick();
    logic          we;
    logic [AW-1:0] d;
    logic [DW-1:0] v;
    we = model_wr_en();
    d  = wb_dest;
    v  = model_wr_data();
    @(posedge clk);
    if (we) begin
      model_regs[d] = v;
      model_cnt     = model_cnt + 1;
    end
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_val(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] exp;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Standard check of both read ports, the forwarding tap and both counters.
  task automatic check_all(input string tag);
    expect_val(model_read(rs_addr));              chk({tag, ":rs_data"}, rs_data);
    expect_val(model_read(rt_addr));              chk({tag, ":rt_data"}, rt_data);
    expect_val({31'b0, model_wr_en()});           chk({tag, ":fwd_valid"}, {31'b0, fwd_valid});
    expect_val(reset ? '0 : model_wr_data());     chk({tag, ":fwd_data"}, fwd_data);
    expect_val({27'b0, wb_dest});                 chk({tag, ":fwd_dest"}, {27'b0, fwd_dest});
    expect_val(model_cnt);                        chk({tag, ":count"}, commit_count);
    expect_val({28'b0, model_cnt[3:0]});          chk({tag, ":count4"}, {28'b0, commit_count4});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [AW-1:0] d;
    logic [DW-1:0] v;
    n_vec = 0;
    n_err = 0;
    model_clear();
    reset = 1'b1;
    drive_wb(2'b00, '0, '0, '0);
    drive_rd('0, '0);
    #1;
    check_all("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Write r5 then assert reset mid-cycle with a write to r5 still pending.
    drive_wb(2'b10, 32'h0, 32'hDEAD_BEEF, 5'd5);
    tick();
    drive_wb(2'b00, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd5, 5'd5);
    #1;
    check_all("r5_written");
    drive_wb(2'b10, 32'h0, 32'hCAFE_0001, 5'd5);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("async_reset");
    tick();                                  // write held across an edge in reset
    check_all("reset_write_suppressed");
    reset = 1'b0;
    drive_wb(2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    check_all("after_reset_r5_zero");

    // Load data selected over ALU result; array visible next cycle.
    drive_wb(2'b11, 32'h1234_5678, 32'hFFFF_0000, 5'd8);
    drive_rd(5'd1, 5'd2);
    #1;
    check_all("memtoreg_fwd");
    tick();
    drive_wb(2'b00, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd0, 5'd8);
    #1;
    check_all("memtoreg_array");

    // Both ports bypass the same write.
    drive_wb(2'b10, 32'h5555_5555, 32'h0000_00AA, 5'd3);
    drive_rd(5'd3, 5'd3);
    #1;
    check_all("dual_bypass");
    tick();
    drive_wb(2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    check_all("dual_bypass_array");

    // RegWrite to $zero: no write, no bypass, no count.
    drive_wb(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    drive_rd(5'd0, 5'd0);
    #1;
    check_all("zero_dest");
    tick();
    check_all("zero_dest_after");

    // No RegWrite: r9 untouched.
    drive_wb(2'b00, 32'h0, 32'h7, 5'd9);
    drive_rd(5'd9, 5'd8);
    #1;
    check_all("no_regwrite");
    tick();
    check_all("no_regwrite_after");

    // 16 consecutive valid writes from a clean counter: 4-bit counter wraps to 0.
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = AW'($urandom_range(1, 31));
      v = $urandom;
      drive_wb({1'b1, 1'($urandom_range(0, 1))}, v, ~v, d);
      drive_rd(d, AW'($urandom_range(0, 31)));
      #1;
      check_all("burst_write");
      tick();
    end
    drive_wb(2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    check_all("count_wrap");
    for (int i = 0; i < 6; i++) begin
      drive_rd(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      #1;
      check_all("burst_readback");
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
